// File: rtl/instr_mem_pkg.sv
// Shared constants and FSM state type for the fetch-stage instruction memory.
package instr_mem_pkg;

  localparam int INSTR_W = 19;
  localparam int IADDR_W = 12;
  localparam logic [INSTR_W-1:0] NOP_DEFAULT = '0;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/instr_mem_ram.sv
// Simple dual-port synchronous RAM, one write and one read port, read-first.
module instr_mem_ram #(
  parameter int DATA_W = 19,
  parameter int DEPTH  = 4096,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clock,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Both ports update on the same edge; the non-blocking read sees the old word.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/instr_mem_ctrl.sv
// Instruction memory controller: clear-after-reset FSM, program-load port and
// a single-stage valid/ready fetch pipeline in front of instr_mem_ram.
module instr_mem_ctrl
  import instr_mem_pkg::*;
#(
  parameter int                DATA_W   = INSTR_W,
  parameter int                ADDR_W   = IADDR_W,
  parameter int                DEPTH    = 4096,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_DEFAULT)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_instr,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_err,
  input  logic              rsp_ready,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              busy
);

  localparam int          RAM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned DEPTH_U = DEPTH;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < DEPTH_U;
  endfunction

  state_e            state, state_nxt;
  logic [RAM_AW-1:0] clr_cnt;
  logic              last_clr;

  logic              we;
  logic [RAM_AW-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              re;
  logic [DATA_W-1:0] ram_rdata;

  logic              accept;
  logic              req_in_range;

  logic              vld_p1;
  logic              err_p1;
  logic              hit_p1;
  logic [ADDR_W-1:0] addr_p1;

  assign last_clr = (clr_cnt == RAM_AW'(DEPTH - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      CLEAR: begin
        busy = 1'b1;
        if (last_clr) state_nxt = RUN;
      end
      RUN:     state_nxt = RUN;
      default: state_nxt = CLEAR;
    endcase
  end

  // Write port belongs to the clear counter until RUN, then to the load port.
  always_comb begin
    we    = 1'b0;
    waddr = clr_cnt;
    wdata = NOP_WORD;
    if (state == CLEAR) begin
      we = 1'b1;
    end else begin
      we    = ld_en && in_range(ld_addr);
      waddr = ld_addr[RAM_AW-1:0];
      wdata = ld_data;
    end
  end

  assign req_ready    = (state == RUN) && (!vld_p1 || rsp_ready);
  assign accept       = req_valid && req_ready;
  assign req_in_range = in_range(req_addr);
  assign re           = accept && req_in_range;

  instr_mem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (RAM_AW)
  ) u_ram (
    .clock (clock),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .re    (re),
    .raddr (req_addr[RAM_AW-1:0]),
    .rdata (ram_rdata)
  );

  // Stage p1: response register; RAM output only advances on an in-range accept.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      err_p1  <= 1'b0;
      hit_p1  <= 1'b0;
      addr_p1 <= '0;
    end else if (accept) begin
      vld_p1  <= 1'b1;
      err_p1  <= !req_in_range;
      hit_p1  <= req_in_range;
      addr_p1 <= req_addr;
    end else if (rsp_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign rsp_valid = vld_p1;
  assign rsp_err   = err_p1;
  assign rsp_addr  = addr_p1;
  assign rsp_instr = hit_p1 ? ram_rdata : NOP_WORD;

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Directed bench for instr_mem_ctrl with DEPTH=16 and an all-ones NOP word.
module tb_instr_mem_ctrl;

  localparam int          DATA_W = 19;
  localparam int          ADDR_W = 12;
  localparam int          DEPTH  = 16;
  localparam logic [18:0] NOP    = 19'h7FFFF;

  logic              clock = 1'b0;
  logic              reset;
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_instr;
  logic [ADDR_W-1:0] rsp_addr;
  logic              rsp_err;
  logic              rsp_ready;
  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              busy;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc;

  instr_mem_ctrl #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .NOP_WORD (NOP)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_instr (rsp_instr),
    .rsp_addr  (rsp_addr),
    .rsp_err   (rsp_err),
    .rsp_ready (rsp_ready),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rsp_now();
    return {31'b0, rsp_valid, rsp_err, rsp_addr, rsp_instr};
  endfunction

  function automatic logic [63:0] rsp_exp(input logic v, input logic e,
                                          input logic [11:0] a, input logic [18:0] d);
    return {31'b0, v, e, a, d};
  endfunction

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;

    // reset state
    tick();
    tick();
    chk("rst_busy",      64'(busy),      64'd1);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp",       rsp_now(),      rsp_exp(1'b0, 1'b0, 12'd0, NOP));

    // clear duration: busy for exactly DEPTH cycles after release
    reset = 1'b0;
    #1;
    cyc = 0;
    while (busy && cyc < 40) begin
      if (req_ready !== 1'b0) chk("clr_req_ready", 64'(req_ready), 64'd0);
      cyc++;
      tick();
    end
    chk("clr_cycles",    64'(cyc),       64'd16);
    rsp_ready = 1'b1;
    #1;
    chk("run_req_ready", 64'(req_ready), 64'd1);

    // every word reads back as NOP after clear, one per cycle
    req_valid = 1'b1;
    req_addr  = 12'd0;
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      chk($sformatf("clr_word_%0d", i), rsp_now(), rsp_exp(1'b1, 1'b0, 12'(i), NOP));
      req_addr = 12'(i + 1);
    end
    req_valid = 1'b0;
    tick();
    chk("drain_valid", 64'(rsp_valid), 64'd0);

    // load two words, then fetch back-to-back
    ld_en = 1'b1; ld_addr = 12'd3; ld_data = 19'h12345;
    tick();
    ld_addr = 12'd4; ld_data = 19'h00011;
    tick();
    ld_en = 1'b0;
    req_valid = 1'b1; req_addr = 12'd3;
    tick();
    chk("ld_fetch3", rsp_now(), rsp_exp(1'b1, 1'b0, 12'd3, 19'h12345));
    req_addr = 12'd4;
    tick();
    chk("ld_fetch4", rsp_now(), rsp_exp(1'b1, 1'b0, 12'd4, 19'h00011));
    req_valid = 1'b0;
    tick();

    // back-pressure
    req_valid = 1'b1; req_addr = 12'd3;
    tick();
    rsp_ready = 1'b0; req_addr = 12'd4;
    #1;
    chk("bp_ready_low", 64'(req_ready), 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("bp_hold_%0d", i), rsp_now(), rsp_exp(1'b1, 1'b0, 12'd3, 19'h12345));
      chk($sformatf("bp_ready_%0d", i), 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(req_ready), 64'd1);
    tick();
    chk("bp_next", rsp_now(), rsp_exp(1'b1, 1'b0, 12'd4, 19'h00011));
    req_valid = 1'b0;
    tick();
    chk("bp_drain", 64'(rsp_valid), 64'd0);

    // read-first collision
    ld_en = 1'b1; ld_addr = 12'd5; ld_data = 19'h0AAAA;
    req_valid = 1'b1; req_addr = 12'd5;
    tick();
    ld_en = 1'b0;
    chk("coll_old", rsp_now(), rsp_exp(1'b1, 1'b0, 12'd5, NOP));
    tick();
    chk("coll_new", rsp_now(), rsp_exp(1'b1, 1'b0, 12'd5, 19'h0AAAA));
    req_valid = 1'b0;
    tick();

    // out of range fetch and dropped load
    req_valid = 1'b1; req_addr = 12'd20;
    tick();
    chk("oor_fetch", rsp_now(), rsp_exp(1'b1, 1'b1, 12'd20, NOP));
    req_valid = 1'b0;
    ld_en = 1'b1; ld_addr = 12'd20; ld_data = 19'h05555;
    tick();
    ld_en = 1'b0;
    req_valid = 1'b1; req_addr = 12'd4;
    tick();
    chk("oor_alias", rsp_now(), rsp_exp(1'b1, 1'b0, 12'd4, 19'h00011));
    req_valid = 1'b0;
    tick();

    // reset while stalled
    req_valid = 1'b1; req_addr = 12'd3;
    tick();
    rsp_ready = 1'b0; req_valid = 1'b0;
    tick();
    chk("mid_stall", rsp_now(), rsp_exp(1'b1, 1'b0, 12'd3, 19'h12345));
    reset = 1'b1;
    tick();
    chk("mid_rst_rsp",  rsp_now(), rsp_exp(1'b0, 1'b0, 12'd0, NOP));
    chk("mid_rst_busy", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    cyc = 0;
    while (busy && cyc < 40) begin
      cyc++;
      tick();
    end
    chk("mid_clr_cycles", 64'(cyc), 64'd16);
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_addr = 12'd3;
    tick();
    chk("mid_fetch3", rsp_now(), rsp_exp(1'b1, 1'b0, 12'd3, NOP));
    req_addr = 12'd4;
    tick();
    chk("mid_fetch4", rsp_now(), rsp_exp(1'b1, 1'b0, 12'd4, NOP));
    req_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_mem_ctrl.md
# instr_mem_ctrl

Parametrised instruction memory for the processor fetch stage. It has a valid/ready fetch handshake with back-pressure, a program-load write port and self-clearing after reset. The pipeline issues program-counter fetches into it, and a testbench or boot loader fills it through the load port instead of hard-wired contents. It is the successor of the fixed 19-bit × 4096 instruction ROM and keeps the same default geometry.

## Interface
Clock is `clock`. Reset is `reset`, synchronous and active-high; the polarity and synchronicity are fixed.

Parameters:
- DATA_W, 19: instruction width in bits.
- ADDR_W, 12: address width in bits.
- DEPTH, 4096: number of implemented words; must satisfy 1 ≤ DEPTH ≤ 2**ADDR_W.
- NOP_WORD, 0: fill value written during clear and returned for out-of-range fetches.

Ports:
- clock, in, 1: the single clock; all logic is on its rising edge.
- reset, in, 1: synchronous, active-high.
- req_valid, in, 1: a fetch request is present.
- req_addr, in, ADDR_W: fetch address.
- req_ready, out, 1: the block accepts a request this cycle.
- rsp_valid, out, 1: rsp_instr and rsp_addr are valid.
- rsp_instr, out, DATA_W: fetched instruction.
- rsp_addr, out, ADDR_W: address that produced rsp_instr.
- rsp_err, out, 1: the response address was ≥ DEPTH; qualified by rsp_valid.
- rsp_ready, in, 1: the consumer takes the response this cycle.
- ld_en, in, 1: program-load write strobe.
- ld_addr, in, ADDR_W: load address.
- ld_data, in, DATA_W: load data.
- busy, out, 1: the block is clearing; fetch and load are unavailable.

## Operation
- Two-state FSM:
  - CLEAR: entered on reset. A clear counter writes NOP_WORD to address 0, 1, … DEPTH-1, one word per cycle. After the DEPTH-1 write the FSM goes to RUN.
  - RUN: normal operation. It is left only by reset.
- CLEAR:
  - busy=1 and req_ready=0.
  - ld_en is ignored and the write is dropped.
- RUN:
  - busy=0.
  - req_ready = !rsp_valid || rsp_ready, a single-stage pipeline register.
- Accept: req_valid && req_ready.
  - The word is read with read-first semantics.
  - On the next edge rsp_valid=1, rsp_addr=req_addr, rsp_instr=mem[req_addr].
  - If req_addr ≥ DEPTH: rsp_instr=NOP_WORD and rsp_err=1. The RAM is not read.
- Stall: while rsp_valid && !rsp_ready, rsp_valid, rsp_instr, rsp_addr and rsp_err hold stable and no new request is accepted.
- Drain: rsp_valid && rsp_ready with no accept in the same cycle clears rsp_valid on the next edge. With an accept in the same cycle, the next response replaces the current one back-to-back.
- Load, in RUN only: ld_en writes ld_data to ld_addr on the edge.
  - If ld_addr ≥ DEPTH the write is dropped silently.
  - Load and fetch are independent and may occur in the same cycle.
- Same-address load and fetch in one cycle: the fetch returns the old word (read-first). The next fetch returns ld_data.
- Reset mid-operation:
  - Any pending response is discarded and rsp_valid goes to 0.
  - The FSM re-enters CLEAR and all prior loads are lost.

## Timing
- Reset values, after the first edge with reset=1:
  - busy=1, req_ready=0, rsp_valid=0, rsp_err=0.
  - rsp_instr=NOP_WORD, rsp_addr=0.
  - Clear counter=0, state=CLEAR.
- Clear duration: with reset released before edge k, the clear writes occur on edges k … k+DEPTH-1. busy=0 and req_ready=1 from after edge k+DEPTH-1.
- Fetch latency is 1 cycle from accept to rsp_valid. Throughput is 1 fetch per cycle while rsp_ready=1.
- Load latency: a word loaded on edge n is visible to a fetch accepted on edge n+1.
- req_ready is combinational from rsp_valid and rsp_ready only. There is no combinational path from req_* to rsp_*.

## Structure
- Package instr_mem_pkg holds:
  - Default constants INSTR_W=19 and IADDR_W=12.
  - Default NOP_WORD.
  - The FSM state enum {CLEAR, RUN}.
- Sub-module instr_mem_ram: a simple dual-port synchronous RAM with one write and one read port, read-first, parameterised by DATA_W and DEPTH.
- The controller multiplexes the write port between the clear counter (CLEAR) and the load port (RUN).
- The response register, the out-of-range flag and the FSM live in instr_mem_ctrl.

## Test plan
- Reset/clear, DEPTH=16, NOP_WORD=19'h7FFFF:
  - Release reset, then busy is high for exactly 16 cycles with req_ready=0.
  - Then fetching addresses 0..15 returns 19'h7FFFF on each, with rsp_err=0.
- Load then fetch:
  - Load 0x12345 to address 3 and 0x00011 to address 4.
  - Fetch 3, then 4, back-to-back with rsp_ready=1: responses arrive on consecutive cycles, 0x12345 then 0x00011, with rsp_addr 3 then 4.
- Back-pressure:
  - Fetch 3, hold rsp_ready=0 for 4 cycles with req_valid=1 at address 4.
  - rsp_instr stays 0x12345 and req_ready=0 throughout.
  - On rsp_ready=1, address 4 is accepted and 0x00011 follows one cycle later.
- Read-first collision:
  - In one cycle, load 0x0AAAA to address 5 (current content NOP_WORD) and fetch address 5: the response is NOP_WORD.
  - A fetch of address 5 on the next cycle returns 0x0AAAA.
- Out of range, DEPTH=16, ADDR_W=12:
  - Fetch address 20: the response is NOP_WORD with rsp_err=1.
  - Load address 20 followed by a fetch of address 4 (20 mod 16): address 4 is unchanged.
- Reset mid-stall:
  - Assert reset while rsp_valid=1 and rsp_ready=0: rsp_valid=0 the next cycle and busy=1.
  - After the clear completes, a fetch of address 3 returns NOP_WORD.
